draw_rect_img: RTL and testbench

- VGA pipeline stage directly downstream of the rectangle position controller.
- Takes the controller's xpos/ypos and the timing/RGB stream from the background stage, and overlays a RECT_W x RECT_H image fetched from an external synchronous-read ROM.
- Passes the timing signals through, delayed to match the ROM read latency.
- Position is sampled once per frame, so the rectangle never tears mid-frame.

---
 rtl/draw_rect_img.sv | 142 ++++++++++++++
 tb/tb_draw_rect_img.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_rect_img.sv
// VGA overlay stage: composites a RECT_W x RECT_H ROM image at a once-per-frame latched position.
// Optional colour-key transparency is enabled with `define DRAW_RECT_TRANSPARENT_EN.
module draw_rect_img #(
    parameter int RECT_W      = 48,
    parameter int RECT_H      = 64,
    parameter int ADDR_X_BITS = 6,
    parameter int ADDR_Y_BITS = 6
`ifdef DRAW_RECT_TRANSPARENT_EN
    ,
    parameter logic [11:0] TRANSPARENT_KEY = 12'hF0F
`endif
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [11:0]                      xpos,
    input  logic [11:0]                      ypos,
    input  logic [10:0]                      hcount_in,
    input  logic [10:0]                      vcount_in,
    input  logic                             hsync_in,
    input  logic                             vsync_in,
    input  logic                             hblnk_in,
    input  logic                             vblnk_in,
    input  logic [11:0]                      rgb_in,
    input  logic [11:0]                      rgb_pixel,
    output logic [ADDR_X_BITS+ADDR_Y_BITS-1:0] pixel_addr,
    output logic [10:0]                      hcount_out,
    output logic [10:0]                      vcount_out,
    output logic                             hsync_out,
    output logic                             vsync_out,
    output logic                             hblnk_out,
    output logic                             vblnk_out,
    output logic [11:0]                      rgb_out
);

    localparam logic [11:0] RECT_W_L = 12'(RECT_W);
    localparam logic [11:0] RECT_H_L = 12'(RECT_H);

    // Latched rectangle position
    logic [11:0] r_x_l;
    logic [11:0] r_y_l;

    // Stage-1 pipeline
    logic [10:0] r_hcount_d1;
    logic [10:0] r_vcount_d1;
    logic        r_hsync_d1;
    logic        r_vsync_d1;
    logic        r_hblnk_d1;
    logic        r_vblnk_d1;
    logic [11:0] r_rgb_d1;
    logic        r_inside_d1;

    // Stage-1 combinational geometry
    logic [11:0] w_dx;
    logic [11:0] w_dy;
    logic        w_h_ge;
    logic        w_v_ge;
    logic        w_inside;
    logic        w_vsync_rise;
    logic [11:0] w_rgb_next;

    // The stage-1 vsync register doubles as the previous-vsync sample for edge detection.
    assign w_vsync_rise = vsync_in & ~r_vsync_d1;

    assign w_dx   = {1'b0, hcount_in} - r_x_l;
    assign w_dy   = {1'b0, vcount_in} - r_y_l;
    assign w_h_ge = ({1'b0, hcount_in} >= r_x_l);
    assign w_v_ge = ({1'b0, vcount_in} >= r_y_l);

    assign w_inside = w_h_ge && (w_dx < RECT_W_L) &&
                      w_v_ge && (w_dy < RECT_H_L) &&
                      !hblnk_in && !vblnk_in;

    // NOTE: every branch assigns after a default, so no latch is inferred.
    always_comb begin
        w_rgb_next = r_rgb_d1;
`ifdef DRAW_RECT_TRANSPARENT_EN
        if (r_inside_d1 && (rgb_pixel != TRANSPARENT_KEY)) begin
            w_rgb_next = rgb_pixel;
        end
`else
        if (r_inside_d1) begin
            w_rgb_next = rgb_pixel;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x_l <= '0;
            r_y_l <= '0;
        end else if (w_vsync_rise) begin
            r_x_l <= xpos;
            r_y_l <= ypos;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcount_d1 <= '0;
            r_vcount_d1 <= '0;
            r_hsync_d1  <= 1'b0;
            r_vsync_d1  <= 1'b0;
            r_hblnk_d1  <= 1'b0;
            r_vblnk_d1  <= 1'b0;
            r_rgb_d1    <= '0;
            r_inside_d1 <= 1'b0;
            pixel_addr  <= '0;
        end else begin
            r_hcount_d1 <= hcount_in;
            r_vcount_d1 <= vcount_in;
            r_hsync_d1  <= hsync_in;
            r_vsync_d1  <= vsync_in;
            r_hblnk_d1  <= hblnk_in;
            r_vblnk_d1  <= vblnk_in;
            r_rgb_d1    <= rgb_in;
            r_inside_d1 <= w_inside;
            pixel_addr  <= w_inside ? {w_dy[ADDR_Y_BITS-1:0], w_dx[ADDR_X_BITS-1:0]} : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= r_hcount_d1;
            vcount_out <= r_vcount_d1;
            hsync_out  <= r_hsync_d1;
            vsync_out  <= r_vsync_d1;
            hblnk_out  <= r_hblnk_d1;
            vblnk_out  <= r_vblnk_d1;
            rgb_out    <= w_rgb_next;
        end
    end

endmodule

// File: tb/tb_draw_rect_img.sv
// Directed self-checking bench for draw_rect_img; the ROM model returns data for the
// stage-1 address in time for the stage-2 edge.
`timescale 1ns/1ps
module tb_draw_rect_img;

    logic        clk;
    logic        rst;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;
    logic [11:0] rgb_pixel;
    logic [11:0] pixel_addr;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    int checks = 0;
    int errors = 0;

    logic        rom_force_en  = 1'b0;
    logic [11:0] rom_force_val = 12'h000;

    function automatic logic [11:0] rom_data(input logic [11:0] a);
        return a ^ 12'h3C5;
    endfunction

    assign rgb_pixel = rom_force_en ? rom_force_val : rom_data(pixel_addr);

    draw_rect_img dut (
        .clk        (clk),
        .rst        (rst),
        .xpos       (xpos),
        .ypos       (ypos),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .rgb_pixel  (rgb_pixel),
        .pixel_addr (pixel_addr),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one pixel, hold it two cycles, return address after stage 1 and colour after stage 2.
    task automatic run_pixel(input logic [10:0] h, input logic [10:0] v, input logic hb,
                             input logic vb, input logic [11:0] bg,
                             output logic [11:0] addr, output logic [11:0] colour);
        @(negedge clk);
        hcount_in = h;
        vcount_in = v;
        hblnk_in  = hb;
        vblnk_in  = vb;
        vsync_in  = 1'b0;
        rgb_in    = bg;
        @(posedge clk);
        #1 addr = pixel_addr;
        @(posedge clk);
        #1 colour = rgb_out;
    endtask

    // Drive a vsync rise with x/y, then scramble xpos/ypos to show they are held.
    task automatic latch_pos(input logic [11:0] x, input logic [11:0] y);
        @(negedge clk);
        xpos = x; ypos = y; vsync_in = 1'b0; vblnk_in = 1'b1; hblnk_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vsync_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vsync_in = 1'b0; vblnk_in = 1'b0; hblnk_in = 1'b0;
        xpos = 12'd999; ypos = 12'd999;
        @(posedge clk);
    endtask

    task automatic test_reset;
        logic [37:0] hist [0:9];
        logic [37:0] got;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            xpos = 12'($urandom); ypos = 12'($urandom);
            hcount_in = 11'($urandom); vcount_in = 11'($urandom);
            hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            hblnk_in = 1'($urandom); vblnk_in = 1'($urandom);
            rgb_in = 12'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({pixel_addr, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
                 vblnk_out, rgb_out} !== 50'd0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got addr=%h h=%h v=%h rgb=%h, want all 0",
                         i, pixel_addr, hcount_out, vcount_out, rgb_out);
            end
        end
        @(negedge clk);
        xpos = 12'd0; ypos = 12'd0;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hcount_in = 11'(200 + 13 * i);
            vcount_in = 11'(300 + 7 * i);
            hsync_in  = 1'(i);
            vsync_in  = 1'(i >> 1);
            hblnk_in  = 1'(i >> 2);
            vblnk_in  = 1'((i + 1) >> 1);
            rgb_in    = 12'(12'h111 * i + 12'h00A);
            hist[i] = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
            @(posedge clk);
            #1;
            if (i >= 1) begin
                got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
                checks++;
                if (got !== hist[i-1] || pixel_addr !== 12'd0) begin
                    errors++;
                    $display("FAIL pipe_delay step %0d: got %h addr=%h, want %h addr=000",
                             i, got, pixel_addr, hist[i-1]);
                end
            end
        end
    endtask

    task automatic test_static;
        logic [11:0] a, c;
        latch_pos(12'd100, 12'd50);
        run_pixel(11'd100, 11'd50, 1'b0, 1'b0, 12'h123, a, c);
        checks++;
        if (a !== 12'd0 || c !== rom_data(12'd0)) begin
            errors++;
            $display("FAIL static_topleft: got addr=%h rgb=%h, want addr=000 rgb=%h", a, c, rom_data(12'd0));
        end
        run_pixel(11'd147, 11'd113, 1'b0, 1'b0, 12'h123, a, c);
        checks++;
        if (a !== 12'd4079 || c !== rom_data(12'd4079)) begin
            errors++;
            $display("FAIL static_botright: got addr=%h rgb=%h, want addr=fef rgb=%h", a, c, rom_data(12'd4079));
        end
        run_pixel(11'd148, 11'd50, 1'b0, 1'b0, 12'h456, a, c);
        checks++;
        if (a !== 12'd0 || c !== 12'h456) begin
            errors++;
            $display("FAIL static_right_out: got addr=%h rgb=%h, want addr=000 rgb=456", a, c);
        end
        run_pixel(11'd99, 11'd50, 1'b0, 1'b0, 12'h789, a, c);
        checks++;
        if (a !== 12'd0 || c !== 12'h789) begin
            errors++;
            $display("FAIL static_left_out: got addr=%h rgb=%h, want addr=000 rgb=789", a, c);
        end
        run_pixel(11'd120, 11'd114, 1'b0, 1'b0, 12'hABC, a, c);
        checks++;
        if (a !== 12'd0 || c !== 12'hABC) begin
            errors++;
            $display("FAIL static_below_out: got addr=%h rgb=%h, want addr=000 rgb=abc", a, c);
        end
        run_pixel(11'd120, 11'd49, 1'b0, 1'b0, 12'hDEF, a, c);
        checks++;
        if (a !== 12'd0 || c !== 12'hDEF) begin
            errors++;
            $display("FAIL static_above_out: got addr=%h rgb=%h, want addr=000 rgb=def", a, c);
        end
    endtask

    task automatic test_midframe_move;
        logic [11:0] a, c;
        latch_pos(12'd100, 12'd150);
        @(negedge clk);
        xpos = 12'd300; ypos = 12'd150;
        run_pixel(11'd100, 11'd200, 1'b0, 1'b0, 12'h321, a, c);
        checks++;
        if (a !== 12'd3200 || c !== rom_data(12'd3200)) begin
            errors++;
            $display("FAIL move_old_pos: got addr=%h rgb=%h, want addr=c80 rgb=%h", a, c, rom_data(12'd3200));
        end
        run_pixel(11'd300, 11'd200, 1'b0, 1'b0, 12'h654, a, c);
        checks++;
        if (a !== 12'd0 || c !== 12'h654) begin
            errors++;
            $display("FAIL move_new_early: got addr=%h rgb=%h, want addr=000 rgb=654", a, c);
        end
        latch_pos(12'd300, 12'd150);
        run_pixel(11'd300, 11'd200, 1'b0, 1'b0, 12'h654, a, c);
        checks++;
        if (a !== 12'd3200 || c !== rom_data(12'd3200)) begin
            errors++;
            $display("FAIL move_next_frame: got addr=%h rgb=%h, want addr=c80 rgb=%h", a, c, rom_data(12'd3200));
        end
        run_pixel(11'd100, 11'd200, 1'b0, 1'b0, 12'h987, a, c);
        checks++;
        if (a !== 12'd0 || c !== 12'h987) begin
            errors++;
            $display("FAIL move_old_gone: got addr=%h rgb=%h, want addr=000 rgb=987", a, c);
        end
    endtask

    task automatic test_edge_clip;
        logic [11:0] a, c;
        latch_pos(12'd780, 12'd580);
        run_pixel(11'd780, 11'd580, 1'b0, 1'b0, 12'h111, a, c);
        checks++;
        if (a !== 12'd0 || c !== rom_data(12'd0)) begin
            errors++;
            $display("FAIL clip_origin: got addr=%h rgb=%h, want addr=000 rgb=%h", a, c, rom_data(12'd0));
        end
        run_pixel(11'd799, 11'd599, 1'b0, 1'b0, 12'h222, a, c);
        checks++;
        if (a !== 12'd1235 || c !== rom_data(12'd1235)) begin
            errors++;
            $display("FAIL clip_corner: got addr=%h rgb=%h, want addr=4d3 rgb=%h", a, c, rom_data(12'd1235));
        end
        run_pixel(11'd10, 11'd590, 1'b0, 1'b0, 12'h333, a, c);
        checks++;
        if (a !== 12'd0 || c !== 12'h333) begin
            errors++;
            $display("FAIL clip_no_wrap_x: got addr=%h rgb=%h, want addr=000 rgb=333", a, c);
        end
        run_pixel(11'd790, 11'd10, 1'b0, 1'b0, 12'h444, a, c);
        checks++;
        if (a !== 12'd0 || c !== 12'h444) begin
            errors++;
            $display("FAIL clip_no_wrap_y: got addr=%h rgb=%h, want addr=000 rgb=444", a, c);
        end
        run_pixel(11'd779, 11'd590, 1'b0, 1'b0, 12'h555, a, c);
        checks++;
        if (a !== 12'd0 || c !== 12'h555) begin
            errors++;
            $display("FAIL clip_left_of: got addr=%h rgb=%h, want addr=000 rgb=555", a, c);
        end
    endtask

    task automatic test_blanking;
        logic [11:0] a, c;
        latch_pos(12'd100, 12'd50);
        run_pixel(11'd110, 11'd60, 1'b1, 1'b0, 12'h0F0, a, c);
        checks++;
        if (a !== 12'd0 || c !== 12'h0F0) begin
            errors++;
            $display("FAIL hblank_inside: got addr=%h rgb=%h, want addr=000 rgb=0f0", a, c);
        end
        run_pixel(11'd110, 11'd60, 1'b0, 1'b1, 12'h00F, a, c);
        checks++;
        if (a !== 12'd0 || c !== 12'h00F) begin
            errors++;
            $display("FAIL vblank_inside: got addr=%h rgb=%h, want addr=000 rgb=00f", a, c);
        end
        run_pixel(11'd110, 11'd60, 1'b0, 1'b0, 12'h00F, a, c);
        checks++;
        if (a !== 12'd650 || c !== rom_data(12'd650)) begin
            errors++;
            $display("FAIL unblank_inside: got addr=%h rgb=%h, want addr=28a rgb=%h", a, c, rom_data(12'd650));
        end
    endtask

    task automatic test_reset_midframe;
        logic [11:0] a, c;
        latch_pos(12'd100, 12'd50);
        run_pixel(11'd110, 11'd60, 1'b0, 1'b0, 12'hFFF, a, c);
        @(negedge clk);
        rst = 1'b0;
        #2;
        checks++;
        if ({pixel_addr, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
             vblnk_out, rgb_out} !== 50'd0) begin
            errors++;
            $display("FAIL async_reset: got addr=%h h=%h v=%h rgb=%h, want all 0 before any edge",
                     pixel_addr, hcount_out, vcount_out, rgb_out);
        end
        @(negedge clk);
        rst = 1'b1;
        run_pixel(11'd0, 11'd0, 1'b0, 1'b0, 12'h777, a, c);
        checks++;
        if (a !== 12'd0 || c !== rom_data(12'd0)) begin
            errors++;
            $display("FAIL reset_pos_origin: got addr=%h rgb=%h, want addr=000 rgb=%h", a, c, rom_data(12'd0));
        end
        run_pixel(11'd100, 11'd50, 1'b0, 1'b0, 12'h777, a, c);
        checks++;
        if (a !== 12'd0 || c !== 12'h777) begin
            errors++;
            $display("FAIL reset_pos_cleared: got addr=%h rgb=%h, want addr=000 rgb=777", a, c);
        end
    endtask

`ifdef DRAW_RECT_TRANSPARENT_EN
    task automatic test_transparent;
        logic [11:0] a, c;
        latch_pos(12'd100, 12'd50);
        rom_force_en = 1'b1;
        rom_force_val = 12'hF0F;
        run_pixel(11'd110, 11'd60, 1'b0, 1'b0, 12'h246, a, c);
        checks++;
        if (c !== 12'h246) begin
            errors++;
            $display("FAIL transparent_key: got rgb=%h, want rgb=246", c);
        end
        rom_force_val = 12'h0A0;
        run_pixel(11'd110, 11'd60, 1'b0, 1'b0, 12'h246, a, c);
        checks++;
        if (c !== 12'h0A0) begin
            errors++;
            $display("FAIL transparent_opaque: got rgb=%h, want rgb=0a0", c);
        end
        rom_force_en = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b0;
        xpos = '0; ypos = '0; hcount_in = '0; vcount_in = '0;
        hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0;
        test_reset;
        test_static;
        test_midframe_move;
        test_edge_clip;
        test_blanking;
        test_reset_midframe;
`ifdef DRAW_RECT_TRANSPARENT_EN
        test_transparent;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
